// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared fetch-unit types, reset PC and instruction field positions.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam logic [31:0] c_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    FETCH      = 2'd1,
    HOLD       = 2'd2
  } fetch_state_t;

  localparam int c_OP_MSB    = 31;
  localparam int c_OP_LSB    = 26;
  localparam int c_RT_MSB    = 20;
  localparam int c_RT_LSB    = 16;
  localparam int c_FUNCT_MSB = 5;
  localparam int c_FUNCT_LSB = 0;
  localparam int c_IMM_MSB   = 15;
  localparam int c_TGT_MSB   = 25;

  // Word-offset immediate to byte offset, sign-extended to 32 bits.
  function automatic logic [31:0] f_branch_offset(input logic [15:0] i_imm);
    return {{14{i_imm[15]}}, i_imm, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/npc_calc.sv
// ============================================================================
// Module : npc_calc
// Brief  : Combinational next-PC selection (jr, j, taken branch, sequential).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module npc_calc
  import cpu_pkg::*;
(
  input  logic [31:0]        i_pc,
  input  logic [c_TGT_MSB:0] i_instr_lo,
  input  logic               i_branch,
  input  logic               i_jump,
  input  logic               i_br_taken,
  input  logic               i_jr_sel,
  input  logic [31:2]        i_rs_word,
  output logic [31:0]        o_pc_plus4,
  output logic [31:0]        o_next_pc
);

  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  logic [31:0] w_jr_target;

  assign w_pc_plus4  = i_pc + 32'd4;
  assign w_br_target = w_pc_plus4 + f_branch_offset(i_instr_lo[c_IMM_MSB:0]);
  assign w_j_target  = {w_pc_plus4[31:28], i_instr_lo, 2'b00};
  // Low two bits are forced to zero; misalignment is flagged by the caller.
  assign w_jr_target = {i_rs_word, 2'b00};

  always_comb begin
    o_next_pc = w_pc_plus4;
    if (i_jump && i_jr_sel) begin
      o_next_pc = w_jr_target;
    end else if (i_jump) begin
      o_next_pc = w_j_target;
    end else if (i_branch && i_br_taken) begin
      o_next_pc = w_br_target;
    end
  end

  assign o_pc_plus4 = w_pc_plus4;

endmodule

`default_nettype wire

// File: rtl/ifu_fetch.sv
// ============================================================================
// Module : ifu_fetch
// Brief  : Instruction fetch unit: fetch / hold FSM, PC and instruction regs.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ifu_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = c_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [4:0]  rt,
  output logic [5:0]  funct,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        Link,
  input  logic        br_taken,
  input  logic        jr_sel,
  input  logic [31:0] rs_data,
  input  logic        commit,
  output logic        align_err
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic         r_instr_valid;
  logic         r_imem_req;
  logic         r_align_err;

  logic [31:0]  w_next_pc;
  logic [31:0]  w_pc_plus4;
  logic         w_jr_misalign;
  logic         w_unused;

  // Link only selects the write-back value downstream; it never steers the PC.
  assign w_unused = Link;

  npc_calc u_npc_calc (
    .i_pc       (r_pc),
    .i_instr_lo (r_instr[c_TGT_MSB:0]),
    .i_branch   (Branch),
    .i_jump     (Jump),
    .i_br_taken (br_taken),
    .i_jr_sel   (jr_sel),
    .i_rs_word  (rs_data[31:2]),
    .o_pc_plus4 (w_pc_plus4),
    .o_next_pc  (w_next_pc)
  );

  assign w_jr_misalign = Jump && jr_sel && (rs_data[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= RESET_WAIT;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_imem_req    <= 1'b0;
      r_align_err   <= 1'b0;
    end else begin
      case (r_state)
        RESET_WAIT: begin
          r_state    <= FETCH;
          r_imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            r_instr       <= imem_rdata;
            r_instr_valid <= 1'b1;
            r_imem_req    <= 1'b0;
            r_state       <= HOLD;
          end
        end
        HOLD: begin
          if (commit) begin
            r_pc          <= w_next_pc;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b1;
            r_state       <= FETCH;
            if (w_jr_misalign) begin
              r_align_err <= 1'b1;
            end
          end
        end
        default: begin
          r_state       <= RESET_WAIT;
          r_instr_valid <= 1'b0;
          r_imem_req    <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign instr       = r_instr;
  assign op          = r_instr[c_OP_MSB:c_OP_LSB];
  assign rt          = r_instr[c_RT_MSB:c_RT_LSB];
  assign funct       = r_instr[c_FUNCT_MSB:c_FUNCT_LSB];
  assign instr_valid = r_instr_valid;
  assign align_err   = r_align_err;

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// ============================================================================
// Module : tb_ifu_fetch
// Brief  : Directed self-checking bench for ifu_fetch.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ifu_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [4:0]  rt;
  logic [5:0]  funct;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        Branch;
  logic        Jump;
  logic        Link;
  logic        br_taken;
  logic        jr_sel;
  logic [31:0] rs_data;
  logic        commit;
  logic        align_err;

  int errors = 0;
  int checks = 0;

  ifu_fetch #(.RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .op          (op),
    .rt          (rt),
    .funct       (funct),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .Branch      (Branch),
    .Jump        (Jump),
    .Link        (Link),
    .br_taken    (br_taken),
    .jr_sel      (jr_sel),
    .rs_data     (rs_data),
    .commit      (commit),
    .align_err   (align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full clock: inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch_word(input logic [31:0] word);
    imem_ready = 1'b1;
    imem_rdata = word;
    step();
    imem_ready = 1'b0;
  endtask

  task automatic do_commit(input logic br, input logic jmp, input logic tk,
                           input logic jr, input logic [31:0] rs, input logic lnk);
    Branch   = br;
    Jump     = jmp;
    br_taken = tk;
    jr_sel   = jr;
    rs_data  = rs;
    Link     = lnk;
    commit   = 1'b1;
    step();
    commit   = 1'b0;
    Branch   = 1'b0;
    Jump     = 1'b0;
    br_taken = 1'b0;
    jr_sel   = 1'b0;
    rs_data  = '0;
    Link     = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = '0;
    Branch     = 1'b0;
    Jump       = 1'b0;
    Link       = 1'b0;
    br_taken   = 1'b0;
    jr_sel     = 1'b0;
    rs_data    = '0;
    commit     = 1'b0;
    @(negedge clk);

    chk("rst_req",    {31'd0, imem_req},    32'd0);
    chk("rst_valid",  {31'd0, instr_valid}, 32'd0);
    chk("rst_pc",     pc,                   32'h0000_3000);
    chk("rst_instr",  instr,                32'd0);
    chk("rst_align",  {31'd0, align_err},   32'd0);
    chk("rst_pc4",    pc_plus4,             32'h0000_3004);

    rst_n = 1'b1;
    step();
    chk("fetch0_req",  {31'd0, imem_req},   32'd1);
    chk("fetch0_addr", imem_addr,           32'h0000_3000);
    chk("fetch0_vld",  {31'd0, instr_valid}, 32'd0);

    fetch_word(32'h2408_0005);
    chk("addi_vld",   {31'd0, instr_valid}, 32'd1);
    chk("addi_req",   {31'd0, imem_req},    32'd0);
    chk("addi_op",    {26'd0, op},          32'h09);
    chk("addi_rt",    {27'd0, rt},          32'd8);
    chk("addi_funct", {26'd0, funct},       32'h05);

    // Data-valid strobes while holding must not disturb the held word.
    fetch_word(32'hDEAD_BEEF);
    chk("hold_ready_ign", instr, 32'h2408_0005);

    do_commit(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("seq_pc",  pc,                   32'h0000_3004);
    chk("seq_req", {31'd0, imem_req},    32'd1);
    chk("seq_vld", {31'd0, instr_valid}, 32'd0);

    // Three stalled fetch cycles; a commit during FETCH is ignored.
    commit = 1'b1;
    step();
    commit = 1'b0;
    chk("stall1_pc",  pc,                   32'h0000_3004);
    chk("stall1_req", {31'd0, imem_req},    32'd1);
    step();
    chk("stall2_vld", {31'd0, instr_valid}, 32'd0);
    step();
    chk("stall3_req", {31'd0, imem_req},    32'd1);
    chk("stall3_vld", {31'd0, instr_valid}, 32'd0);
    fetch_word(32'h1000_FFFF);
    chk("stall_hold", {31'd0, instr_valid}, 32'd1);

    do_commit(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    chk("beq_back", imem_addr, 32'h0000_3004);

    fetch_word(32'h1000_0003);
    do_commit(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("beq_nt", pc, 32'h0000_3008);

    fetch_word(32'h0800_0C04);
    chk("j_pc4", pc_plus4, 32'h0000_300C);
    do_commit(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    chk("j_prio", imem_addr, 32'h0000_3010);

    fetch_word(32'h0220_0008);
    do_commit(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_3021, 1'b0);
    chk("jr_addr",  imem_addr,          32'h0000_3020);
    chk("jr_align", {31'd0, align_err}, 32'd1);

    fetch_word(32'h0220_0008);
    do_commit(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    chk("jr_hi",        pc,                 32'hFFFF_FFFC);
    chk("align_sticky", {31'd0, align_err}, 32'd1);
    fetch_word(32'h0000_0000);
    chk("wrap_pc4", pc_plus4, 32'h0000_0000);
    do_commit(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("wrap_pc", pc, 32'h0000_0000);

    // Reset asserted mid-cycle while holding an instruction.
    fetch_word(32'h2408_0005);
    chk("pre_rst_vld", {31'd0, instr_valid}, 32'd1);
    commit     = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'h1234_5678;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_vld",   {31'd0, instr_valid}, 32'd0);
    chk("arst_pc",    pc,                   32'h0000_3000);
    chk("arst_align", {31'd0, align_err},   32'd0);
    chk("arst_instr", instr,                32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_req",   {31'd0, imem_req},    32'd1);
    chk("post_rst_vld",   {31'd0, instr_valid}, 32'd0);
    chk("post_rst_instr", instr,                32'd0);
    imem_ready = 1'b0;
    step();
    chk("post_rst_cmt", pc, 32'h0000_3000);
    fetch_word(32'h2408_0005);
    chk("post_rst_hold", {31'd0, instr_valid}, 32'd1);
    step();
    commit = 1'b0;
    chk("post_rst_adv", pc, 32'h0000_3004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule

`default_nettype wire
